// File: rtl/parking_keypad_entry_if.sv
// parking_keypad_entry_if: keypad strobes and gate-controller signals for the password initiator.
interface parking_keypad_entry_if;
   logic       key_valid;
   logic [1:0] key_code;
   logic       key_clear;
   logic       gate_waiting;
   logic       gate_open;
   logic [1:0] password_1;
   logic [1:0] password_2;
   logic       pw_valid;
   logic       locked;
   logic [1:0] attempts_left;
   logic [1:0] digit_count;
   modport master (
      output key_valid, key_code, key_clear, gate_waiting, gate_open,
      input  password_1, password_2, pw_valid, locked, attempts_left, digit_count
   );
   modport slave (
      input  key_valid, key_code, key_clear, gate_waiting, gate_open,
      output password_1, password_2, pw_valid, locked, attempts_left, digit_count
   );
endinterface

// File: rtl/parking_keypad_entry.sv
// parking_keypad_entry: collects two key digits, presents them to the gate, tracks failures and lockout.
module parking_keypad_entry #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int HOLD_CYCLES    = 4,
   parameter int MAX_ATTEMPTS   = 3,
   parameter int LOCKOUT_CYCLES = 5000
) (
   input logic                   clk,
   input logic                   reset,
   parking_keypad_entry_if.slave kp_if
);
   typedef enum logic [2:0] {IDLE, DIGIT1, DIGIT2, PRESENT, DONE, LOCKOUT} state_e;
   localparam logic [15:0] T_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0] H_LAST = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0] L_LAST = 16'(LOCKOUT_CYCLES - 1);
   localparam logic [1:0]  ATT_MAX = 2'(MAX_ATTEMPTS);
   state_e      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [1:0]  d1_q, d1_d, pw1_q, pw1_d, pw2_q, pw2_d, att_q, att_d, cnt_q, cnt_d;
   logic        pwv_q, pwv_d, lock_q, lock_d;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         timer_q <= '0;
         d1_q    <= '0;
         pw1_q   <= '0;
         pw2_q   <= '0;
         pwv_q   <= 1'b0;
         lock_q  <= 1'b0;
         att_q   <= ATT_MAX;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         d1_q    <= d1_d;
         pw1_q   <= pw1_d;
         pw2_q   <= pw2_d;
         pwv_q   <= pwv_d;
         lock_q  <= lock_d;
         att_q   <= att_d;
         cnt_q   <= cnt_d;
      end
   end
   // The single timer free-runs in every state and is cleared on each transition or key event.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q + 16'd1;
      d1_d    = d1_q;
      pw1_d   = pw1_q;
      pw2_d   = pw2_q;
      pwv_d   = pwv_q;
      lock_d  = lock_q;
      att_d   = att_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            timer_d = '0;
            cnt_d   = '0;
            state_d = kp_if.gate_waiting ? DIGIT1 : IDLE;
         end
         DIGIT1: begin
            if (!kp_if.gate_waiting || (!kp_if.key_clear && !kp_if.key_valid && timer_q == T_LAST)) begin
               state_d = IDLE;
               timer_d = '0;
               cnt_d   = '0;
            end else if (kp_if.key_clear) begin
               timer_d = '0;
            end else if (kp_if.key_valid) begin
               d1_d    = kp_if.key_code;
               cnt_d   = 2'd1;
               state_d = DIGIT2;
               timer_d = '0;
            end
         end
         DIGIT2: begin
            if (!kp_if.gate_waiting || (!kp_if.key_clear && !kp_if.key_valid && timer_q == T_LAST)) begin
               state_d = IDLE;
               timer_d = '0;
               cnt_d   = '0;
            end else if (kp_if.key_clear) begin
               state_d = DIGIT1;
               timer_d = '0;
               cnt_d   = '0;
            end else if (kp_if.key_valid) begin
               pw1_d   = d1_q;
               pw2_d   = kp_if.key_code;
               pwv_d   = 1'b1;
               cnt_d   = 2'd2;
               state_d = PRESENT;
               timer_d = '0;
            end
         end
         PRESENT: begin
            if (kp_if.gate_open || timer_q == H_LAST) begin
               pw1_d   = '0;
               pw2_d   = '0;
               pwv_d   = 1'b0;
               cnt_d   = '0;
               timer_d = '0;
               if (kp_if.gate_open) begin
                  att_d   = ATT_MAX;
                  state_d = DONE;
               end else begin
                  att_d   = att_q - {1'b0, |att_q};
                  lock_d  = att_q <= 2'd1;
                  state_d = (att_q <= 2'd1) ? LOCKOUT : kp_if.gate_waiting ? DIGIT1 : IDLE;
               end
            end
         end
         DONE: begin
            timer_d = '0;
            state_d = kp_if.gate_open ? DONE : IDLE;
         end
         LOCKOUT: begin
            if (timer_q == L_LAST) begin
               lock_d  = 1'b0;
               att_d   = ATT_MAX;
               state_d = IDLE;
               timer_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   assign kp_if.password_1    = pw1_q;
   assign kp_if.password_2    = pw2_q;
   assign kp_if.pw_valid      = pwv_q;
   assign kp_if.locked        = lock_q;
   assign kp_if.attempts_left = att_q;
   assign kp_if.digit_count   = cnt_q;
endmodule

// File: tb/tb_parking_keypad_entry.sv
// tb_parking_keypad_entry: scenario tasks plus randomized entries against an attempt/lockout model.
module tb_parking_keypad_entry;
   localparam int TMO = 1000, HOLD = 4, MAXA = 3, LOCK = 5000;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int total = 0, bad = 0, att_m = MAXA;
   logic [1:0] s1 = 2'b01, s2 = 2'b10;
   parking_keypad_entry_if kp ();
   parking_keypad_entry #(
      .TIMEOUT_CYCLES(TMO), .HOLD_CYCLES(HOLD), .MAX_ATTEMPTS(MAXA), .LOCKOUT_CYCLES(LOCK)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .kp_if(kp)
   );
   always #5 clk = ~clk;
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic press(input logic [1:0] c, input logic clr);
      kp.key_valid = 1'b1;
      kp.key_code  = c;
      kp.key_clear = clr;
      @(negedge clk);
      kp.key_valid = 1'b0;
      kp.key_clear = 1'b0;
   endtask
   task automatic clear_key();
      kp.key_clear = 1'b1;
      @(negedge clk);
      kp.key_clear = 1'b0;
   endtask
   task automatic run_lockout();
      int n = 0;
      bit moved = 0;
      while (kp.locked === 1'b1 && n < LOCK + 1000) begin
         n++;
         kp.key_valid = 1'($urandom_range(0, 1));
         kp.key_code  = 2'($urandom);
         @(negedge clk);
         if (kp.digit_count !== 2'd0 || kp.pw_valid !== 1'b0) moved = 1;
      end
      kp.key_valid = 1'b0;
      att_m = MAXA;
      total++; if (n != LOCK) begin bad++; $display("FAIL lock_len: got %0d want %0d", n, LOCK); end
      total++; if (moved) begin bad++; $display("FAIL lock_keys: digit_count/pw_valid moved got 1 want 0"); end
      total++; if (kp.attempts_left !== 2'(MAXA)) begin bad++; $display("FAIL lock_reload: got %0d want %0d", kp.attempts_left, MAXA); end
      total++; if (kp.locked !== 1'b0) begin bad++; $display("FAIL lock_end: got %b want 0", kp.locked); end
   endtask
   // Enter a, b and act as the gate: accept (raise gate_open on the 3rd presenting cycle) only if a/b match s1/s2.
   task automatic present(input logic [1:0] a, input logic [1:0] b);
      bit ok, vals_ok;
      int n, exp_n;
      ok = (a == s1) && (b == s2);
      exp_n = ok ? 3 : HOLD;
      press(a, 1'b0);
      total++; if (kp.digit_count !== 2'd1) begin bad++; $display("FAIL digit1_count: got %0d want 1", kp.digit_count); end
      press(b, 1'b0);
      n = 0;
      vals_ok = 1;
      while (kp.pw_valid === 1'b1 && n < 20) begin
         n++;
         if (kp.password_1 !== a || kp.password_2 !== b) vals_ok = 0;
         if (ok && n == 3) kp.gate_open = 1'b1;
         @(negedge clk);
      end
      att_m = ok ? MAXA : att_m - 1;
      total++; if (!vals_ok) begin bad++; $display("FAIL pw_values: got %b/%b want %b/%b", kp.password_1, kp.password_2, a, b); end
      total++; if (n != exp_n) begin bad++; $display("FAIL pw_len: got %0d want %0d", n, exp_n); end
      total++; if (kp.attempts_left !== 2'(att_m)) begin bad++; $display("FAIL attempts: got %0d want %0d", kp.attempts_left, att_m); end
      total++; if (kp.password_1 !== 2'b00 || kp.password_2 !== 2'b00 || kp.digit_count !== 2'd0) begin
         bad++; $display("FAIL pw_release: got %b/%b cnt=%0d want 00/00 cnt=0", kp.password_1, kp.password_2, kp.digit_count);
      end
      total++; if (kp.locked !== (att_m == 0)) begin bad++; $display("FAIL locked_after: got %b want %b", kp.locked, att_m == 0); end
      if (ok) begin
         step(2);
         kp.gate_open = 1'b0;
      end
      if (att_m == 0) run_lockout();
      step(3);
   endtask
   task automatic test_reset();
      kp.key_valid = 0; kp.key_code = 0; kp.key_clear = 0; kp.gate_waiting = 0; kp.gate_open = 0;
      reset = 1'b1;
      step(2);
      total++; if (kp.pw_valid !== 1'b0 || kp.locked !== 1'b0) begin bad++; $display("FAIL reset_flags: got pwv=%b lock=%b want 0 0", kp.pw_valid, kp.locked); end
      total++; if (kp.password_1 !== 2'b00 || kp.password_2 !== 2'b00) begin bad++; $display("FAIL reset_pw: got %b/%b want 00/00", kp.password_1, kp.password_2); end
      total++; if (kp.attempts_left !== 2'(MAXA) || kp.digit_count !== 2'd0) begin bad++; $display("FAIL reset_counts: got att=%0d cnt=%0d want %0d 0", kp.attempts_left, kp.digit_count, MAXA); end
      reset = 1'b0;
      kp.gate_waiting = 1'b1;
      step(3);
   endtask
   task automatic test_correct();
      s1 = 2'b01; s2 = 2'b10;
      present(2'b01, 2'b10);
   endtask
   task automatic test_lockout();
      s1 = 2'b00; s2 = 2'b01;
      repeat (MAXA) present(2'b11, 2'b11);
   endtask
   task automatic test_timeout();
      press(2'b01, 1'b0);
      step(TMO - 1);
      total++; if (kp.digit_count !== 2'd1) begin bad++; $display("FAIL timeout_early: got %0d want 1", kp.digit_count); end
      step(1);
      total++; if (kp.digit_count !== 2'd0) begin bad++; $display("FAIL timeout_fire: got %0d want 0", kp.digit_count); end
      total++; if (kp.attempts_left !== 2'(att_m) || kp.pw_valid !== 1'b0 || kp.password_1 !== 2'b00 || kp.password_2 !== 2'b00) begin
         bad++; $display("FAIL timeout_state: got att=%0d pwv=%b pw=%b/%b want %0d 0 00/00", kp.attempts_left, kp.pw_valid, kp.password_1, kp.password_2, att_m);
      end
      step(3);
   endtask
   task automatic test_clear();
      press(2'b11, 1'b0);
      clear_key();
      total++; if (kp.digit_count !== 2'd0) begin bad++; $display("FAIL clear_d2: got %0d want 0", kp.digit_count); end
      press(2'b11, 1'b1);
      total++; if (kp.digit_count !== 2'd0) begin bad++; $display("FAIL clear_wins_d1: got %0d want 0", kp.digit_count); end
      press(2'b01, 1'b0);
      press(2'b10, 1'b1);
      total++; if (kp.digit_count !== 2'd0 || kp.pw_valid !== 1'b0) begin bad++; $display("FAIL clear_wins_d2: got cnt=%0d pwv=%b want 0 0", kp.digit_count, kp.pw_valid); end
      s1 = 2'b01; s2 = 2'b10;
      present(2'b01, 2'b10);
   endtask
   task automatic test_abort();
      press(2'b01, 1'b0);
      kp.gate_waiting = 1'b0;
      step(1);
      total++; if (kp.digit_count !== 2'd0 || kp.attempts_left !== 2'(att_m)) begin
         bad++; $display("FAIL abort: got cnt=%0d att=%0d want 0 %0d", kp.digit_count, kp.attempts_left, att_m);
      end
      kp.gate_waiting = 1'b1;
      step(3);
   endtask
   task automatic test_reset_mid();
      s1 = 2'b00; s2 = 2'b00;
      press(2'b11, 1'b0);
      press(2'b10, 1'b0);
      step(1);
      reset = 1'b1;
      step(1);
      total++; if (kp.pw_valid !== 1'b0 || kp.password_1 !== 2'b00 || kp.password_2 !== 2'b00 || kp.attempts_left !== 2'(MAXA)) begin
         bad++; $display("FAIL reset_mid: got pwv=%b pw=%b/%b att=%0d want 0 00/00 %0d", kp.pw_valid, kp.password_1, kp.password_2, kp.attempts_left, MAXA);
      end
      reset = 1'b0;
      att_m = MAXA;
      step(3);
      s1 = 2'b10; s2 = 2'b01;
      present(2'b10, 2'b01);
   endtask
   task automatic test_random();
      logic [1:0] a, b;
      for (int i = 0; i < 10; i++) begin
         a = 2'($urandom);
         b = 2'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            s1 = a; s2 = b;
         end else begin
            s1 = a + 2'($urandom_range(1, 3)); s2 = b;
         end
         present(a, b);
      end
   endtask
   initial begin
      test_reset();
      test_correct();
      test_lockout();
      test_timeout();
      test_clear();
      test_abort();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/parking_keypad_entry.md
Name: parking_keypad_entry

Overview:
Keypad-side password initiator for the car parking gate controller. It collects two 2-bit key digits from a keypad strobe interface and presents them on the gate controller's password_1/password_2 inputs. It then watches the controller's green-LED feedback to judge success or failure, counts failed attempts, and enforces a lockout. It sits between the keypad scanner and the gate controller.

Parameters:
TIMEOUT_CYCLES, 1000, idle cycles allowed between key presses before the entry is discarded (2..65535)
HOLD_CYCLES, 4, cycles the password stays presented while waiting for gate_open (min 4; gate response latency is 3 cycles)
MAX_ATTEMPTS, 3, failed presentations allowed before lockout (1..3)
LOCKOUT_CYCLES, 5000, lockout duration in cycles (1..65535)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
key_valid  input  1  single-cycle strobe; key_code is valid
key_code  input  2  digit value
key_clear  input  1  single-cycle strobe; discard digits entered so far
gate_waiting  input  1  gate controller is in WAIT_PASSWORD or STOP (red LED on, car present)
gate_open  input  1  gate controller green LED
password_1  output  2  first digit to gate controller; 2'b00 when not presenting
password_2  output  2  second digit to gate controller; 2'b00 when not presenting
pw_valid  output  1  high while password_1/password_2 are being presented
locked  output  1  high during lockout
attempts_left  output  2  remaining attempts
digit_count  output  2  digits captured so far (0..2)

Behaviour:
- All outputs are registered. One 16-bit timer serves the timeout, hold and lockout functions.
- Reset (synchronous, any state, including mid-presentation): state IDLE; password_1 = password_2 = 2'b00; pw_valid = 0; locked = 0; digit_count = 0; attempts_left = MAX_ATTEMPTS; timer = 0. Outputs take these values on the first clock edge with reset high.
- States: IDLE, DIGIT1, DIGIT2, PRESENT, DONE, LOCKOUT.
- IDLE: go to DIGIT1 when gate_waiting = 1. Clear the timer.
- DIGIT1:
  - key_valid: latch key_code as d1, digit_count = 1, go to DIGIT2, clear the timer.
  - key_clear: clear the timer only.
  - Timer reaches TIMEOUT_CYCLES-1 with no key event: go to IDLE; no attempt is consumed.
- DIGIT2:
  - key_valid: latch d2, digit_count = 2, go to PRESENT, clear the timer.
  - key_clear: digit_count = 0, return to DIGIT1.
  - Timeout behaves as in DIGIT1: digits discarded, go to IDLE.
- Same cycle key_valid and key_clear: clear wins; the key is dropped.
- gate_waiting = 0 in DIGIT1 or DIGIT2: go to IDLE, digit_count = 0, no attempt consumed.
- PRESENT:
  - The cycle after entry: password_1 = d1, password_2 = d2, pw_valid = 1. Hold these for up to HOLD_CYCLES cycles.
  - key_valid and key_clear are ignored.
  - gate_open = 1 on any presenting cycle means success: attempts_left reloads to MAX_ATTEMPTS, go to DONE.
  - Hold expires without gate_open means failure: attempts_left decrements.
    - If the new value is 0: go to LOCKOUT.
    - Else if gate_waiting = 1: go to DIGIT1.
    - Else: go to IDLE.
  - On leaving PRESENT, password outputs return to 2'b00, pw_valid = 0 and digit_count = 0 on the same edge.
- DONE: wait for gate_open = 0, then go to IDLE. Keys are ignored.
- LOCKOUT:
  - locked = 1; all keys are ignored.
  - After LOCKOUT_CYCLES cycles: locked = 0, attempts_left = MAX_ATTEMPTS, go to IDLE.
  - gate_waiting has no effect.
- Password outputs are never nonzero outside PRESENT. 00/00 is never a valid code, so the gate controller does not mis-accept.
- attempts_left does not underflow and is reloaded only on success, on lockout expiry, or on reset.

Test Plan:
- Correct code: gate_waiting = 1; keys 01 then 10; gate model raises gate_open 3 cycles after presentation. Required: pw_valid high for 3 cycles with password_1 = 01 and password_2 = 10; attempts_left = 3; DONE, then IDLE after gate_open falls.
- Three wrong codes (11/11): pw_valid high for 4 cycles each; attempts_left goes 2, 1, 0; locked = 1 for 5000 cycles. Keys during lockout produce no digit_count change. Afterwards attempts_left = 3 and locked = 0.
- Timeout: key 01 then no key for 1000 cycles. Required: IDLE, digit_count = 0, attempts_left unchanged, password outputs 00.
- Clear: keys 11, clear, 01, 10. Required: presents 01/10. A same-cycle key_valid plus key_clear captures no digit.
- Abort: gate_waiting drops after the first digit. Required: IDLE next cycle, digit_count = 0, no attempt consumed.
- Reset mid-PRESENT: pw_valid = 0, password outputs 00 and attempts_left = 3 after the reset edge; no stale digits are presented on the next entry.
